// File: rtl/mode_disp_mux.sv
// Display-source selector for the digital clock.
// Holds the current display mode and maps each mode to one of N_CH
// (digit-select, segment) channels. Outputs are forced off for a few cycles
// after each mode change to stop the old digits ghosting onto the new ones.
// Masked modes additionally blink their segments.
module mode_disp_mux #(
  parameter int                       N_CH       = 4,
  parameter int                       CW         = 2,
  parameter int                       N_MODE     = 4,
  parameter int                       MW         = 2,
  parameter int                       W_LEG      = 8,
  parameter int                       W_DIS      = 8,
  parameter logic [N_MODE*CW-1:0]     MODE_MAP   = 8'b10_00_01_00,
  parameter logic [N_MODE-1:0]        BLINK_MASK = 4'b0100,
  parameter int                       BLINK_HALF = 500,
  parameter int                       BLANK_CYC  = 4,
  parameter logic [W_LEG-1:0]         LEG_OFF    = '1,
  parameter logic [W_DIS-1:0]         DIS_OFF    = '1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode_step,
  input  logic                    mode_load,
  input  logic [MW-1:0]           mode_in,
  input  logic [N_CH*W_LEG-1:0]   leg_in,
  input  logic [N_CH*W_DIS-1:0]   dis_in,
  output logic [W_LEG-1:0]        lego,
  output logic [W_DIS-1:0]        diso,
  output logic [MW-1:0]           mode,
  output logic                    sw_busy
);

  localparam int BKW = $clog2(BLANK_CYC + 1);
  localparam int BLW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [MW-1:0]    mode_reg, mode_next;
  logic [BKW-1:0]   blank_cnt_reg, blank_cnt_next;
  logic [BLW-1:0]   blink_cnt_reg, blink_cnt_next;
  logic             phase_off_reg, phase_off_next;
  logic [W_LEG-1:0] lego_reg, lego_next;
  logic [W_DIS-1:0] diso_reg, diso_next;

  // Per-mode flag: the mapped channel actually exists (fixed by parameters).
  logic [N_MODE-1:0] map_ok;

  genvar gi;
  generate
    for (gi = 0; gi < N_MODE; gi++) begin : g_map_ok
      assign map_ok[gi] = (int'(MODE_MAP[gi*CW +: CW]) < N_CH);
    end
  endgenerate

  logic [MW-1:0]    mode_cand;
  logic [31:0]      mode_in_ext;
  logic             mode_change;
  logic [CW-1:0]    ch;
  logic [W_LEG-1:0] sel_leg;
  logic [W_DIS-1:0] sel_dis;

  // Next-state: mode selection, blanking count, blink timer and output data.
  always_comb begin
    mode_next      = mode_reg;
    blank_cnt_next = blank_cnt_reg;
    blink_cnt_next = blink_cnt_reg;
    phase_off_next = phase_off_reg;
    lego_next      = LEG_OFF;
    diso_next      = DIS_OFF;
    sel_leg        = LEG_OFF;
    sel_dis        = DIS_OFF;
    mode_in_ext    = 32'(mode_in);

    // Load wins over step; an out-of-range load swallows the step as well.
    if (mode_load) begin
      mode_cand = (mode_in_ext < N_MODE) ? mode_in : mode_reg;
    end else if (mode_step) begin
      mode_cand = (mode_reg == MW'(N_MODE - 1)) ? '0 : mode_reg + 1'b1;
    end else begin
      mode_cand = mode_reg;
    end
    mode_change = (mode_cand != mode_reg);

    // Free-running blink timer; phase flips every BLINK_HALF cycles.
    if (blink_cnt_reg == BLW'(BLINK_HALF - 1)) begin
      blink_cnt_next = '0;
      phase_off_next = ~phase_off_reg;
    end else begin
      blink_cnt_next = blink_cnt_reg + 1'b1;
    end

    // Channel data for the current mode; only segments are blinked so the
    // digit scan keeps running.
    ch = MODE_MAP[mode_reg*CW +: CW];
    if (map_ok[mode_reg]) begin
      sel_leg = leg_in[ch*W_LEG +: W_LEG];
      sel_dis = (BLINK_MASK[mode_reg] && phase_off_reg) ? DIS_OFF
                                                        : dis_in[ch*W_DIS +: W_DIS];
    end

    if (mode_change) begin
      mode_next      = mode_cand;
      blank_cnt_next = BKW'(BLANK_CYC);
      blink_cnt_next = '0;
      phase_off_next = 1'b0;
    end else if (blank_cnt_reg > BKW'(1)) begin
      blank_cnt_next = blank_cnt_reg - 1'b1;
    end else begin
      // Last blanking edge (count 1) already presents the new channel.
      if (blank_cnt_reg != '0) begin
        blank_cnt_next = blank_cnt_reg - 1'b1;
      end
      lego_next = sel_leg;
      diso_next = sel_dis;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_reg      <= '0;
      blank_cnt_reg <= '0;
      blink_cnt_reg <= '0;
      phase_off_reg <= 1'b0;
      lego_reg      <= LEG_OFF;
      diso_reg      <= DIS_OFF;
    end else begin
      mode_reg      <= mode_next;
      blank_cnt_reg <= blank_cnt_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_off_reg <= phase_off_next;
      lego_reg      <= lego_next;
      diso_reg      <= diso_next;
    end
  end

  assign lego    = lego_reg;
  assign diso    = diso_reg;
  assign mode    = mode_reg;
  assign sw_busy = (blank_cnt_reg != '0);

endmodule

// File: tb/tb_mode_disp_mux.sv
// Directed bench for mode_disp_mux with a short blink half-period.
module tb_mode_disp_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_step;
  logic        mode_load;
  logic [1:0]  mode_in;
  logic [31:0] leg_in;
  logic [31:0] dis_in;
  logic [7:0]  lego;
  logic [7:0]  diso;
  logic [1:0]  mode;
  logic        sw_busy;

  int checks   = 0;
  int failures = 0;

  mode_disp_mux #(.BLINK_HALF(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_step (mode_step),
    .mode_load (mode_load),
    .mode_in   (mode_in),
    .leg_in    (leg_in),
    .dis_in    (dis_in),
    .lego      (lego),
    .diso      (diso),
    .mode      (mode),
    .sw_busy   (sw_busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_leg, input logic [7:0] e_dis,
                         input logic [1:0] e_mode, input logic e_busy);
    chk({tag, ".lego"}, 32'(lego), 32'(e_leg));
    chk({tag, ".diso"}, 32'(diso), 32'(e_dis));
    chk({tag, ".mode"}, 32'(mode), 32'(e_mode));
    chk({tag, ".busy"}, 32'(sw_busy), 32'(e_busy));
    $display("t=%0t %s lego=%02h diso=%02h mode=%0d busy=%0d", $time, tag, lego, diso, mode, sw_busy);
  endtask

  // Pulse step/load for one edge, then expect 4 OFF cycles and new data.
  task automatic change_chk(input string tag, input logic st, input logic ld, input logic [1:0] mi,
                            input logic [1:0] e_mode, input logic [7:0] e_leg, input logic [7:0] e_dis);
    mode_step = st; mode_load = ld; mode_in = mi;
    tick();
    mode_step = 1'b0; mode_load = 1'b0;
    chk_all({tag, "@E"}, 8'hFF, 8'hFF, e_mode, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_all($sformatf("%s@E+%0d", tag, i), 8'hFF, 8'hFF, e_mode, 1'b1);
    end
    tick();
    chk_all({tag, "@E+4"}, e_leg, e_dis, e_mode, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; mode_step = 1'b0; mode_load = 1'b0; mode_in = 2'd0;
    leg_in = {8'h44, 8'h33, 8'h22, 8'h11};
    dis_in = {8'hD4, 8'hC3, 8'hB2, 8'hA1};

    // Reset and release.
    tick(); tick();
    chk_all("reset", 8'hFF, 8'hFF, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_all("idle0", 8'h11, 8'hA1, 2'd0, 1'b0);

    // Step through every mode with wrap.
    change_chk("step1", 1'b1, 1'b0, 2'd0, 2'd1, 8'h22, 8'hB2);
    change_chk("step2", 1'b1, 1'b0, 2'd0, 2'd2, 8'h11, 8'hA1);
    change_chk("step3", 1'b1, 1'b0, 2'd0, 2'd3, 8'h33, 8'hC3);
    change_chk("wrap0", 1'b1, 1'b0, 2'd0, 2'd0, 8'h11, 8'hA1);

    // Load beats simultaneous step; reloading the same mode is not a change.
    change_chk("ldwin", 1'b1, 1'b1, 2'd3, 2'd3, 8'h33, 8'hC3);
    mode_load = 1'b1; mode_in = 2'd3;
    tick();
    mode_load = 1'b0;
    chk_all("ldsame", 8'h33, 8'hC3, 2'd3, 1'b0);
    tick();
    chk_all("ldsame+1", 8'h33, 8'hC3, 2'd3, 1'b0);

    // Blink in set mode: ON through E+4, OFF E+5..E+8, ON E+9..E+12, OFF E+13.
    change_chk("ldset", 1'b0, 1'b1, 2'd2, 2'd2, 8'h11, 8'hA1);
    for (int i = 5; i <= 13; i++) begin
      tick();
      chk_all($sformatf("blink@E+%0d", i), 8'h11, (i >= 9 && i <= 12) ? 8'hA1 : 8'hFF, 2'd2, 1'b0);
    end

    // Second change during blanking restarts the count.
    change_chk("ld0", 1'b0, 1'b1, 2'd0, 2'd0, 8'h11, 8'hA1);
    mode_step = 1'b1;
    tick();
    mode_step = 1'b0;
    chk_all("rs@E", 8'hFF, 8'hFF, 2'd1, 1'b1);
    tick();
    chk_all("rs@E+1", 8'hFF, 8'hFF, 2'd1, 1'b1);
    mode_step = 1'b1;
    tick();
    mode_step = 1'b0;
    chk_all("rs@E+2", 8'hFF, 8'hFF, 2'd2, 1'b1);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk_all($sformatf("rs@E+%0d", i), 8'hFF, 8'hFF, 2'd2, 1'b1);
    end
    tick();
    chk_all("rs@E+6", 8'h11, 8'hA1, 2'd2, 1'b0);

    // Reset in the middle of blanking into mode 2.
    mode_load = 1'b1; mode_in = 2'd0;
    tick();
    mode_in = 2'd2;
    tick();
    mode_load = 1'b0;
    chk_all("pre_rst", 8'hFF, 8'hFF, 2'd2, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all("mid_rst", 8'hFF, 8'hFF, 2'd0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_all($sformatf("post_rst+%0d", i), 8'h11, 8'hA1, 2'd0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
